// File: rtl/decode_pkg.sv
// Shared constants for the RV32I decode stage: major opcodes, funct3 codes,
// ALU operation encodings and immediate field widths.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam int IMM_I_W = 12;
    localparam int IMM_S_W = 12;
    localparam int IMM_B_W = 13;
    localparam int IMM_U_W = 32;
    localparam int IMM_J_W = 21;

    // alt selects sub for funct3=000 and sra for funct3=101.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I instruction decoder.
// Ports: instr (in) -> register indices, alu_op, sign-extended imm, control
// strobes, illegal flag, and uses_rs1/uses_rs2 for hazard detection.
module decode_fields
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 4
) (
    input  logic [31:0]         instr,
    output logic [REG_AW-1:0]   rs1,
    output logic [REG_AW-1:0]   rs2,
    output logic [REG_AW-1:0]   rd,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     imm,
    output logic                alu_src,
    output logic                rw_sel,
    output logic                mr_sel,
    output logic                mw_sel,
    output logic                mtr_sel,
    output logic                branch_sel,
    output logic                jump_sel,
    output logic                illegal,
    output logic                uses_rs1,
    output logic                uses_rs2
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    alu_op_e     op;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    assign rs1 = REG_AW'(instr[19:15]);
    assign rs2 = REG_AW'(instr[24:20]);
    assign rd  = REG_AW'(instr[11:7]);

    assign imm_i = {{(32-IMM_I_W){instr[31]}}, instr[31:20]};
    assign imm_s = {{(32-IMM_S_W){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(32-IMM_B_W){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], {(IMM_U_W-20){1'b0}}};
    assign imm_j = {{(32-IMM_J_W){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        op         = ALU_ADD;
        imm32      = '0;
        alu_src    = 1'b0;
        rw_sel     = 1'b0;
        mr_sel     = 1'b0;
        mw_sel     = 1'b0;
        mtr_sel    = 1'b0;
        branch_sel = 1'b0;
        jump_sel   = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                op     = alu_from_funct3(funct3, instr[30]);
                rw_sel = 1'b1;
            end
            OPC_OP_IMM: begin
                // addi has no subtract form; only the shift-right honours bit 30
                op      = alu_from_funct3(funct3, instr[30] && (funct3 == F3_SR));
                imm32   = imm_i;
                alu_src = 1'b1;
                rw_sel  = 1'b1;
            end
            OPC_LOAD: begin
                imm32   = imm_i;
                alu_src = 1'b1;
                mr_sel  = 1'b1;
                mtr_sel = 1'b1;
                rw_sel  = 1'b1;
            end
            OPC_STORE: begin
                imm32   = imm_s;
                alu_src = 1'b1;
                mw_sel  = 1'b1;
            end
            OPC_BRANCH: begin
                op         = ALU_SUB;
                imm32      = imm_b;
                branch_sel = 1'b1;
            end
            OPC_LUI: begin
                op      = ALU_PASS_B;
                imm32   = imm_u;
                alu_src = 1'b1;
                rw_sel  = 1'b1;
            end
            OPC_AUIPC: begin
                imm32   = imm_u;
                alu_src = 1'b1;
                rw_sel  = 1'b1;
            end
            OPC_JAL: begin
                imm32    = imm_j;
                jump_sel = 1'b1;
                rw_sel   = 1'b1;
            end
            OPC_JALR: begin
                imm32    = imm_i;
                alu_src  = 1'b1;
                jump_sel = 1'b1;
                rw_sel   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign alu_op = ALU_OP_W'(op);
    assign imm    = XLEN'($signed(imm32));

    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage between fetch and execute.
// Ports: clk/rst (sync, active-high); fetch side in_valid/in_ready/in_instr/
// in_pc; flush; execute side out_valid/out_ready plus the decoded bundle
// (out_pc, rs1, rs2, rd, alu_op, imm, control strobes, illegal).
// A load followed by a dependent instruction stalls intake for one cycle.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [REG_AW-1:0]   rs1,
    output logic [REG_AW-1:0]   rs2,
    output logic [REG_AW-1:0]   rd,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     imm,
    output logic                alu_src,
    output logic                rw_sel,
    output logic                mr_sel,
    output logic                mw_sel,
    output logic                mtr_sel,
    output logic                branch_sel,
    output logic                jump_sel,
    output logic                illegal
);

    logic [REG_AW-1:0]   f_rs1, f_rs2, f_rd;
    logic [ALU_OP_W-1:0] f_alu_op;
    logic [XLEN-1:0]     f_imm;
    logic f_alu_src, f_rw_sel, f_mr_sel, f_mw_sel, f_mtr_sel;
    logic f_branch_sel, f_jump_sel, f_illegal, f_uses_rs1, f_uses_rs2;
    logic haz;

    decode_fields #(
        .XLEN     (XLEN),
        .REG_AW   (REG_AW),
        .ALU_OP_W (ALU_OP_W)
    ) u_fields (
        .instr      (in_instr),
        .rs1        (f_rs1),
        .rs2        (f_rs2),
        .rd         (f_rd),
        .alu_op     (f_alu_op),
        .imm        (f_imm),
        .alu_src    (f_alu_src),
        .rw_sel     (f_rw_sel),
        .mr_sel     (f_mr_sel),
        .mw_sel     (f_mw_sel),
        .mtr_sel    (f_mtr_sel),
        .branch_sel (f_branch_sel),
        .jump_sel   (f_jump_sel),
        .illegal    (f_illegal),
        .uses_rs1   (f_uses_rs1),
        .uses_rs2   (f_uses_rs2)
    );

    // Held load whose result the incoming instruction reads; x0 never counts.
    assign haz = out_valid && mr_sel && (rd != '0) && in_valid &&
                 ((f_uses_rs1 && (f_rs1 == rd)) || (f_uses_rs2 && (f_rs2 == rd)));

    assign in_ready = !flush && !haz && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            rs1        <= '0;
            rs2        <= '0;
            rd         <= '0;
            alu_op     <= '0;
            imm        <= '0;
            alu_src    <= 1'b0;
            rw_sel     <= 1'b0;
            mr_sel     <= 1'b0;
            mw_sel     <= 1'b0;
            mtr_sel    <= 1'b0;
            branch_sel <= 1'b0;
            jump_sel   <= 1'b0;
            illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            rs1        <= f_rs1;
            rs2        <= f_rs2;
            rd         <= f_rd;
            alu_op     <= f_alu_op;
            imm        <= f_imm;
            alu_src    <= f_alu_src;
            rw_sel     <= f_rw_sel;
            mr_sel     <= f_mr_sel;
            mw_sel     <= f_mw_sel;
            mtr_sel    <= f_mtr_sel;
            branch_sel <= f_branch_sel;
            jump_sel   <= f_jump_sel;
            illegal    <= f_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
